// File: rtl/pipeline_pkg.sv
// Shared types and constants for the debug single-step controller.
package pipeline_pkg;

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} step_state_t;

    localparam int unsigned STEP_DEBOUNCE_SIM  = 4;
    localparam int unsigned STEP_DEBOUNCE_FPGA = 500000;

endpackage

// File: rtl/step_ctrl_sync2.sv
// Two-flop synchronizer with configurable reset value.
// The first-stage output is exposed so the consumer can see the value
// that the synchronized output will take on the next edge.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q_early,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_early <= RST_VAL;
            q       <= RST_VAL;
        end else begin
            q_early <= d;
            q       <= q_early;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Debug single-step controller: synchronizes and debounces the step button
// and mode switch, and produces the pipeline advance enable.
import pipeline_pkg::*;

module step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = STEP_DEBOUNCE_SIM,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_button,
    input  logic             step_enable,
    output logic             run_en,
    output logic             step_pulse,
    output logic             step_mode,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic btn_s;
    logic btn_early;
    logic mode_next;

    step_state_t     state, state_next;
    logic [DB_W-1:0] cnt, cnt_next;
    logic            accept;
    logic            pulse_next;
    logic            run_next;

    sync2 #(.RST_VAL(1'b1)) u_btn_sync (
        .clk     (clk),
        .rst     (rst),
        .d       (step_button),
        .q_early (btn_early),
        .q       (btn_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_mode_sync (
        .clk     (clk),
        .rst     (rst),
        .d       (step_enable),
        .q_early (mode_next),
        .q       (step_mode)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!btn_s) begin
                    state_next = DB_PRESS;
                    cnt_next   = '0;
                end
            end
            DB_PRESS: begin
                if (btn_s) begin
                    state_next = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_next = HELD;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt + DB_W'(1);
                end
            end
            HELD: begin
                if (btn_s) begin
                    state_next = DB_REL;
                    cnt_next   = '0;
                end
            end
            DB_REL: begin
                if (!btn_s) begin
                    state_next = HELD;
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + DB_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Gate with the mode value taking effect on this edge so a switch to
        // free run on the acceptance edge suppresses the pulse; run_en stays
        // low only while step mode holds on both sides of the edge.
        pulse_next = accept & mode_next;
        run_next   = ~(step_mode & mode_next) | pulse_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            step_pulse <= 1'b0;
            run_en     <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            step_pulse <= pulse_next;
            run_en     <= run_next;
            if (pulse_next)
                step_count <= step_count + CNT_W'(1);
        end
    end

    logic unused_btn_early;
    assign unused_btn_early = btn_early;

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl against a sample-window reference model.
module tb_step_ctrl;
    import pipeline_pkg::*;

    localparam int unsigned D  = STEP_DEBOUNCE_SIM;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          step_button;
    logic          step_enable;
    logic          run_en;
    logic          step_pulse;
    logic          step_mode;
    logic [CW-1:0] step_count;

    always #5 clk = ~clk;

    step_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .step_button (step_button),
        .step_enable (step_enable),
        .run_en      (run_en),
        .step_pulse  (step_pulse),
        .step_mode   (step_mode),
        .step_count  (step_count)
    );

    // Reference: pin values sampled one and two edges back, the last D+1
    // synchronized button samples, and the accepted (pressed) level.
    bit          bp1, bp2, mp1, mp2, held;
    bit          win[$];
    bit          m_pulse, m_run;
    int unsigned m_count;
    int unsigned n_checks, n_pass, n_fail;
    int unsigned pulses_seen;
    int unsigned p0;

    function automatic void model_reset();
        bp1 = 1'b1; bp2 = 1'b1; mp1 = 1'b0; mp2 = 1'b0; held = 1'b0;
        win.delete();
        for (int i = 0; i <= int'(D); i++) win.push_back(1'b1);
        m_pulse = 1'b0; m_run = 1'b0; m_count = 0;
    endfunction

    function automatic void model_edge();
        bit bs, mode_old, mode_new, all_lo, all_hi, acc;
        bs = bp2; mode_old = mp2; mode_new = mp1;
        bp2 = bp1; bp1 = step_button;
        mp2 = mp1; mp1 = step_enable;
        win.push_back(bs);
        void'(win.pop_front());
        all_lo = 1'b1; all_hi = 1'b1;
        foreach (win[i]) begin
            if (win[i]) all_lo = 1'b0;
            else        all_hi = 1'b0;
        end
        acc = 1'b0;
        if (!held && all_lo) begin
            held = 1'b1;
            acc  = 1'b1;
        end else if (held && all_hi) begin
            held = 1'b0;
        end
        m_pulse = acc && mode_new;
        if (m_pulse) m_count = (m_count + 1) % (1 << CW);
        m_run = !(mode_old && mode_new) || m_pulse;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("run_en",     32'(run_en),     32'(m_run));
        check("step_pulse", 32'(step_pulse), 32'(m_pulse));
        check("step_mode",  32'(step_mode),  32'(mp2));
        check("step_count", 32'(step_count), m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        if (step_pulse) pulses_seen++;
        check_all();
    endtask

    task automatic run(input logic b, input logic m, input int unsigned n);
        step_button = b;
        step_enable = m;
        repeat (n) tick();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0; pulses_seen = 0;
        rst = 1'b0; step_button = 1'b1; step_enable = 1'b0;
        model_reset();
        #21;
        check_all();
        rst = 1'b1;

        // Free run after reset release
        run(1'b1, 1'b0, 5);
        check("free_run_en", 32'(run_en), 32'd1);

        // Single press in step mode
        run(1'b1, 1'b1, 3);
        p0 = pulses_seen;
        run(1'b0, 1'b1, 6);
        run(1'b1, 1'b1, 8);
        check("press_pulses", pulses_seen - p0, 32'd1);

        // Short glitch
        p0 = pulses_seen;
        run(1'b0, 1'b1, 2);
        run(1'b1, 1'b1, 10);
        check("glitch_pulses", pulses_seen - p0, 32'd0);

        // Long hold then second press
        p0 = pulses_seen;
        run(1'b0, 1'b1, 50);
        check("hold_pulses", pulses_seen - p0, 32'd1);
        run(1'b1, 1'b1, 6);
        run(1'b0, 1'b1, 8);
        run(1'b1, 1'b1, 8);
        check("repress_pulses", pulses_seen - p0, 32'd2);

        // Press accepted in free run, then switch to step mode while held
        p0 = pulses_seen;
        run(1'b0, 1'b0, 20);
        run(1'b0, 1'b1, 10);
        check("held_switch_pulses", pulses_seen - p0, 32'd0);
        run(1'b1, 1'b1, 8);
        run(1'b0, 1'b1, 8);
        run(1'b1, 1'b1, 8);
        check("new_press_pulses", pulses_seen - p0, 32'd1);

        // Mode drops to free run on the acceptance edge
        p0 = pulses_seen;
        run(1'b0, 1'b1, 5);
        run(1'b0, 1'b0, 5);
        run(1'b1, 1'b0, 8);
        check("same_edge_pulses", pulses_seen - p0, 32'd0);

        // Five presses exercise count wrap
        run(1'b1, 1'b1, 6);
        p0 = pulses_seen;
        for (int i = 0; i < 5; i++) begin
            run(1'b0, 1'b1, 7);
            run(1'b1, 1'b1, 7);
        end
        check("wrap_pulses", pulses_seen - p0, 32'd5);

        // Randomized segments
        for (int i = 0; i < 60; i++) begin
            logic b, m;
            b = 1'($urandom_range(0, 1));
            m = ($urandom_range(0, 5) == 0) ? ~step_enable : step_enable;
            run(b, m, $urandom_range(1, 9));
        end

        // Reset mid-debounce
        run(1'b1, 1'b1, 8);
        run(1'b0, 1'b1, 4);
        #2;
        rst = 1'b0;
        #1;
        check("rst_run_en",     32'(run_en),     32'd0);
        check("rst_step_pulse", 32'(step_pulse), 32'd0);
        check("rst_step_mode",  32'(step_mode),  32'd0);
        check("rst_step_count", 32'(step_count), 32'd0);
        model_reset();
        run(1'b0, 1'b1, 3);
        rst = 1'b1;
        run(1'b1, 1'b1, 10);
        run(1'b0, 1'b1, 8);
        run(1'b1, 1'b1, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
